// File: rtl/pipe_defs_pkg.sv
// Shared ID/EX pipeline definitions: field widths, ALUOp encodings and the control bundle.
package pipe_defs;

  localparam int REG_AW  = 5;
  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 2;

  // Classic MIPS main-decoder ALUOp values
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_IMM   = 2'b11;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t ID_EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use hazard detection; a flush masks the stall since the ID instruction is dropped anyway.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              flush_i,
  output logic              hazard_o,
  output logic              stall_o
);

  // $0 is hard-wired to zero, so a load targeting it never creates a dependency
  assign hazard_o = ex_mem_read_i && (ex_rt_i != '0) &&
                    ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
  assign stall_o  = hazard_o && !flush_i;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register, 1-cycle latency; stall is combinational and lasts one cycle per load-use dependency.
// Defining ID_EX_STALL_CNT_EN adds a saturating stall_count output.
module id_ex_stage_reg #(
  parameter int DATA_W  = pipe_defs::DATA_W,
  parameter int REG_AW  = pipe_defs::REG_AW,
  parameter int ALUOP_W = pipe_defs::ALUOP_W
`ifdef ID_EX_STALL_CNT_EN
  , parameter int STALL_CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [REG_AW-1:0]  IF_ID_RegisterRs,
  input  logic [REG_AW-1:0]  IF_ID_RegisterRt,
  input  logic [REG_AW-1:0]  IF_ID_RegisterRd,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_MemToReg,
  input  logic               ID_ALUSrc,
  input  logic               ID_RegDst,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  output logic [REG_AW-1:0]  ID_EX_RegisterRs,
  output logic [REG_AW-1:0]  ID_EX_RegisterRt,
  output logic [REG_AW-1:0]  ID_EX_RegisterRd,
  output logic [DATA_W-1:0]  ID_EX_ReadData1,
  output logic [DATA_W-1:0]  ID_EX_ReadData2,
  output logic [DATA_W-1:0]  ID_EX_Imm,
  output logic               ID_EX_RegWrite,
  output logic               ID_EX_MemRead,
  output logic               ID_EX_MemWrite,
  output logic               ID_EX_MemToReg,
  output logic               ID_EX_ALUSrc,
  output logic               ID_EX_RegDst,
  output logic [ALUOP_W-1:0] ID_EX_ALUOp,
  output logic               stall
`ifdef ID_EX_STALL_CNT_EN
  , output logic [STALL_CNT_W-1:0] stall_count
`endif
);

  import pipe_defs::*;

  id_ex_ctrl_t        ctrl_d, ctrl_q;
  logic [ALUOP_W-1:0] alu_op_d, alu_op_q;
  logic [REG_AW-1:0]  rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic [DATA_W-1:0]  rdata1_d, rdata1_q, rdata2_d, rdata2_q, imm_d, imm_q;
  logic               hazard;
  logic               load_bubble;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rt_i       (rt_q),
    .id_rs_i       (IF_ID_RegisterRs),
    .id_rt_i       (IF_ID_RegisterRt),
    .flush_i       (flush),
    .hazard_o      (hazard),
    .stall_o       (stall)
  );

  // flush | stall reduces to flush | hazard
  assign load_bubble = flush || hazard;

  always_comb begin
    ctrl_d   = ID_EX_CTRL_BUBBLE;
    alu_op_d = '0;
    rs_d     = '0;
    rt_d     = '0;
    rd_d     = '0;
    rdata1_d = '0;
    rdata2_d = '0;
    imm_d    = '0;
    if (!load_bubble) begin
      ctrl_d   = '{reg_write:  ID_RegWrite,
                   mem_read:   ID_MemRead,
                   mem_write:  ID_MemWrite,
                   mem_to_reg: ID_MemToReg,
                   alu_src:    ID_ALUSrc,
                   reg_dst:    ID_RegDst};
      alu_op_d = ID_ALUOp;
      rs_d     = IF_ID_RegisterRs;
      rt_d     = IF_ID_RegisterRt;
      rd_d     = IF_ID_RegisterRd;
      rdata1_d = ID_ReadData1;
      rdata2_d = ID_ReadData2;
      imm_d    = ID_Imm;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= ID_EX_CTRL_BUBBLE;
      alu_op_q <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      alu_op_q <= alu_op_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
    end
  end

  assign ID_EX_RegisterRs = rs_q;
  assign ID_EX_RegisterRt = rt_q;
  assign ID_EX_RegisterRd = rd_q;
  assign ID_EX_ReadData1  = rdata1_q;
  assign ID_EX_ReadData2  = rdata2_q;
  assign ID_EX_Imm        = imm_q;
  assign ID_EX_RegWrite   = ctrl_q.reg_write;
  assign ID_EX_MemRead    = ctrl_q.mem_read;
  assign ID_EX_MemWrite   = ctrl_q.mem_write;
  assign ID_EX_MemToReg   = ctrl_q.mem_to_reg;
  assign ID_EX_ALUSrc     = ctrl_q.alu_src;
  assign ID_EX_RegDst     = ctrl_q.reg_dst;
  assign ID_EX_ALUOp      = alu_op_q;

`ifdef ID_EX_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: an instruction-level model predicts stall and the EX contents per cycle.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm;
    logic        rw, mr, mw, m2r, as, rdst;
    logic [1:0]  op;
  } ex_t;

  typedef struct {
    logic stall;
    ex_t  ex;
    int   cnt;
  } item_t;

`ifdef ID_EX_STALL_CNT_EN
  localparam int CW = 4;
  logic [CW-1:0] stall_count;
`endif
  localparam int CNT_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  ex_t  id_in = '0;

  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic        ex_rw, ex_mr, ex_mw, ex_m2r, ex_as, ex_rdst, stall;
  logic [1:0]  ex_op;

  item_t q[$];
  ex_t   m_ex = '0;
  int    m_cnt = 0;
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

`ifdef ID_EX_STALL_CNT_EN
  id_ex_stage_reg #(.STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .IF_ID_RegisterRs(id_in.rs), .IF_ID_RegisterRt(id_in.rt), .IF_ID_RegisterRd(id_in.rd),
    .ID_ReadData1(id_in.rd1), .ID_ReadData2(id_in.rd2), .ID_Imm(id_in.imm),
    .ID_RegWrite(id_in.rw), .ID_MemRead(id_in.mr), .ID_MemWrite(id_in.mw),
    .ID_MemToReg(id_in.m2r), .ID_ALUSrc(id_in.as), .ID_RegDst(id_in.rdst), .ID_ALUOp(id_in.op),
    .ID_EX_RegisterRs(ex_rs), .ID_EX_RegisterRt(ex_rt), .ID_EX_RegisterRd(ex_rd),
    .ID_EX_ReadData1(ex_rd1), .ID_EX_ReadData2(ex_rd2), .ID_EX_Imm(ex_imm),
    .ID_EX_RegWrite(ex_rw), .ID_EX_MemRead(ex_mr), .ID_EX_MemWrite(ex_mw),
    .ID_EX_MemToReg(ex_m2r), .ID_EX_ALUSrc(ex_as), .ID_EX_RegDst(ex_rdst), .ID_EX_ALUOp(ex_op),
    .stall(stall),
    .stall_count(stall_count)
  );
`else
  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .IF_ID_RegisterRs(id_in.rs), .IF_ID_RegisterRt(id_in.rt), .IF_ID_RegisterRd(id_in.rd),
    .ID_ReadData1(id_in.rd1), .ID_ReadData2(id_in.rd2), .ID_Imm(id_in.imm),
    .ID_RegWrite(id_in.rw), .ID_MemRead(id_in.mr), .ID_MemWrite(id_in.mw),
    .ID_MemToReg(id_in.m2r), .ID_ALUSrc(id_in.as), .ID_RegDst(id_in.rdst), .ID_ALUOp(id_in.op),
    .ID_EX_RegisterRs(ex_rs), .ID_EX_RegisterRt(ex_rt), .ID_EX_RegisterRd(ex_rd),
    .ID_EX_ReadData1(ex_rd1), .ID_EX_ReadData2(ex_rd2), .ID_EX_Imm(ex_imm),
    .ID_EX_RegWrite(ex_rw), .ID_EX_MemRead(ex_mr), .ID_EX_MemWrite(ex_mw),
    .ID_EX_MemToReg(ex_m2r), .ID_EX_ALUSrc(ex_as), .ID_EX_RegDst(ex_rdst), .ID_EX_ALUOp(ex_op),
    .stall(stall)
  );
`endif

  function automatic ex_t dut_ex();
    return {ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2, ex_imm,
            ex_rw, ex_mr, ex_mw, ex_m2r, ex_as, ex_rdst, ex_op};
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ex(input string name, input ex_t act, input ex_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level view: the ID instruction must wait if it reads the
  // non-zero register a load in EX is about to produce; a redirect kills it.
  function automatic bit waits_on_load(input ex_t ex, input ex_t id);
    if (!ex.mr || ex.rt == 5'd0) return 1'b0;
    return (id.rs == ex.rt) || (id.rt == ex.rt);
  endfunction

  task automatic issue(input ex_t id, input bit fl);
    item_t it;
    bit    dep;
    @(negedge clk);
    id_in = id;
    flush = fl;
    dep = waits_on_load(m_ex, id);
    it.stall = dep && !fl;
    m_ex = (fl || dep) ? ex_t'('0) : id;
    if (it.stall) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    it.ex  = m_ex;
    it.cnt = m_cnt;
    q.push_back(it);
  endtask

  function automatic ex_t rand_ex();
    ex_t e;
    e.rs   = 5'($urandom_range(0, 7));
    e.rt   = 5'($urandom_range(0, 7));
    e.rd   = 5'($urandom_range(0, 31));
    e.rd1  = $urandom;
    e.rd2  = $urandom;
    e.imm  = $urandom;
    e.rw   = 1'($urandom_range(0, 1));
    e.mr   = 1'($urandom_range(0, 1));
    e.mw   = 1'($urandom_range(0, 1));
    e.m2r  = 1'($urandom_range(0, 1));
    e.as   = 1'($urandom_range(0, 1));
    e.rdst = 1'($urandom_range(0, 1));
    e.op   = 2'($urandom_range(0, 3));
    return e;
  endfunction

  function automatic ex_t mk(input int rs, input int rt, input int rd,
                             input bit rw, input bit mr, input int rd1);
    ex_t e = '0;
    e.rs = 5'(rs); e.rt = 5'(rt); e.rd = 5'(rd);
    e.rw = rw; e.mr = mr; e.m2r = mr; e.as = mr;
    e.rd1 = 32'(rd1);
    e.imm = mr ? 32'h10 : 32'h0;
    return e;
  endfunction

  // Monitor: pops one expectation per issued instruction
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        it = q.pop_front();
        chk_bit("stall", stall, it.stall);
        @(posedge clk);
        #1;
        chk_ex("id_ex_regs", dut_ex(), it.ex);
`ifdef ID_EX_STALL_CNT_EN
        chk_int("stall_count", int'(stall_count), it.cnt);
`endif
      end
    end
  end

  initial begin
    ex_t lw8, dep8, lw0, use0, lw9, dep9;
    lw8  = mk(1, 8, 0, 1'b1, 1'b1, 0);
    dep8 = mk(8, 2, 9, 1'b1, 1'b0, 32'h55);
    lw0  = mk(1, 0, 0, 1'b1, 1'b1, 0);
    use0 = mk(0, 0, 6, 1'b1, 1'b0, 32'h77);
    lw9  = mk(8, 9, 0, 1'b1, 1'b1, 0);
    dep9 = mk(9, 3, 10, 1'b1, 1'b0, 32'h99);

    #2;
    chk_ex("reset_outputs", dut_ex(), '0);
    chk_bit("reset_stall", stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    issue(mk(3, 4, 5, 1'b1, 1'b0, 32'h1234), 1'b0);
    issue(lw8, 1'b0);
    issue(dep8, 1'b0);
    issue(dep8, 1'b0);
    issue(lw0, 1'b0);
    issue(use0, 1'b0);
    issue(lw8, 1'b0);
    issue(dep8, 1'b1);
    issue(dep8, 1'b0);
    issue(lw8, 1'b0);
    issue(lw9, 1'b0);
    issue(lw9, 1'b0);
    issue(dep9, 1'b0);
    issue(dep9, 1'b0);

    for (int i = 0; i < 300; i++) begin
      issue(rand_ex(), ($urandom_range(0, 7) == 0));
    end

    // Reset while a stall is in progress
    issue(lw8, 1'b0);
    @(negedge clk);
    id_in = dep8;
    flush = 1'b0;
    #1;
    chk_bit("stall_before_reset", stall, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_ex("midrun_reset_outputs", dut_ex(), '0);
    chk_bit("midrun_reset_stall", stall, 1'b0);
`ifdef ID_EX_STALL_CNT_EN
    chk_int("midrun_reset_count", int'(stall_count), 0);
`endif
    m_ex  = '0;
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    issue(dep8, 1'b0);

    for (int i = 0; i < 20; i++) begin
      issue(mk(1, 9, 0, 1'b1, 1'b1, 0), 1'b0);
      issue(dep9, 1'b0);
      issue(dep9, 1'b0);
    end
    issue(mk(2, 2, 2, 1'b0, 1'b0, 1), 1'b0);

    repeat (3) @(negedge clk);
    chk_int("queue_drained", q.size(), 0);
`ifdef ID_EX_STALL_CNT_EN
    chk_int("stall_count_saturated", int'(stall_count), CNT_MAX);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
